// File: rtl/fifo_uart_tx_if.sv
// Connection bundle between a sync_fifo read port and the fifo_uart_tx serial stage.
// fifo_rd_en is a one-cycle pop request that is only raised while the stage is idle.
// Standard mode: fifo_valid marks fifo_data for the single cycle after that pop.
// FWFT mode: fifo_data is the head word whenever fifo_empty is low, and fifo_valid is unused.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_valid;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic             frame_done;
  logic             rd_err;
  logic [15:0]      frame_count;

  modport master (
    input  fifo_data, fifo_empty, fifo_valid,
    output fifo_rd_en, tx, busy, frame_done, rd_err, frame_count
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_valid,
    input  fifo_rd_en, tx, busy, frame_done, rd_err, frame_count
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains words from a sync_fifo and sends each as an async serial frame:
// start bit, WIDTH data bits LSB-first, optional even parity, STOP_BITS stop bits.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1,
  parameter int FWFT         = 0
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus,
  output logic [2:0]     dbg_state
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    clk_cnt, clk_cnt_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [1:0]       wait_cnt, wait_cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, shreg_shr;
  logic             par, par_nx;
  logic             tx_q, tx_nx;
  logic             busy_q, busy_nx;
  logic             rd_en_q, rd_en_nx;
  logic             done_q, done_nx;
  logic             err_q, err_nx;
  logic [15:0]      cnt_q, cnt_nx;
  logic             bit_end;

  assign bit_end   = (clk_cnt == CLK_LAST);
  assign shreg_shr = shreg >> 1;

  always_comb begin
    state_nx    = state;
    clk_cnt_nx  = '0;
    bit_cnt_nx  = bit_cnt;
    wait_cnt_nx = wait_cnt;
    shreg_nx    = shreg;
    par_nx      = par;
    tx_nx       = tx_q;
    busy_nx     = busy_q;
    rd_en_nx    = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    cnt_nx      = cnt_q;
    if (state != IDLE && state != WAIT) begin
      clk_cnt_nx = bit_end ? '0 : clk_cnt + 1'b1;
    end
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!bus.fifo_empty) begin
          rd_en_nx = 1'b1;
          if (FWFT != 0) begin
            // Head word is already on fifo_data, so the start bit goes out now.
            shreg_nx = bus.fifo_data;
            par_nx   = ^bus.fifo_data;
            tx_nx    = 1'b0;
            busy_nx  = 1'b1;
            state_nx = START;
          end else begin
            wait_cnt_nx = '0;
            state_nx    = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.fifo_valid) begin
          shreg_nx = bus.fifo_data;
          par_nx   = ^bus.fifo_data;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
          state_nx = START;
        end else if (wait_cnt == 2'd3) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          tx_nx      = shreg[0];
          bit_cnt_nx = '0;
          state_nx   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nx = '0;
            if (PARITY_EN != 0) begin
              tx_nx    = par;
              state_nx = PARITY;
            end else begin
              tx_nx    = 1'b1;
              state_nx = STOP;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
            shreg_nx   = shreg_shr;
            tx_nx      = shreg_shr[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_nx      = 1'b1;
          bit_cnt_nx = '0;
          state_nx   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            cnt_nx   = cnt_q + 16'd1;
            state_nx = IDLE;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nx;
      clk_cnt  <= clk_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      wait_cnt <= wait_cnt_nx;
      shreg    <= shreg_nx;
      par      <= par_nx;
      tx_q     <= tx_nx;
      busy_q   <= busy_nx;
      rd_en_q  <= rd_en_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
      cnt_q    <= cnt_nx;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.fifo_rd_en  = rd_en_q;
  assign bus.frame_done  = done_q;
  assign bus.rd_err      = err_q;
  assign bus.frame_count = cnt_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a standard-mode DUT (no parity) and an FWFT DUT (even parity),
// both with CLKS_PER_BIT=4, fed by small FIFO models and checked by a UART-decoding monitor.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx_if #(.WIDTH(8)) s_if ();
  fifo_uart_tx_if #(.WIDTH(8)) f_if ();
  logic [2:0] s_dbg, f_dbg;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(s_if), .dbg_state(s_dbg));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1), .FWFT(1))
    u_fw (.clk(clk), .rst(rst), .bus(f_if), .dbg_state(f_dbg));

  // FIFO models (not reset: the FIFO is a separate block)
  logic [7:0] s_fq[$], f_fq[$];
  logic       s_wr = 1'b0, f_wr = 1'b0, suppress = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       s_empty = 1'b1, s_valid = 1'b0, f_empty = 1'b1;
  logic [7:0] s_data = 8'h00, f_data = 8'h00;

  assign s_if.fifo_empty = s_empty;
  assign s_if.fifo_valid = s_valid;
  assign s_if.fifo_data  = s_data;
  assign f_if.fifo_empty = f_empty;
  assign f_if.fifo_valid = 1'b0;
  assign f_if.fifo_data  = f_data;

  always @(posedge clk) begin
    if (s_wr) s_fq.push_back(wr_data);
    s_valid <= 1'b0;
    if (s_if.fifo_rd_en && s_fq.size() > 0) begin
      s_data  <= s_fq.pop_front();
      s_valid <= !suppress;
    end
    s_empty <= (s_fq.size() == 0);
  end

  always @(posedge clk) begin
    if (f_wr) f_fq.push_back(wr_data);
    if (f_if.fifo_rd_en && f_fq.size() > 0) void'(f_fq.pop_front());
    f_empty <= (f_fq.size() == 0);
    f_data  <= (f_fq.size() > 0) ? f_fq[0] : 8'h00;
  end

  // Scoreboard state
  int n_vec = 0, n_err = 0;
  logic [10:0] exp_q[$];
  int fall_q[$];
  logic mode = 1'b0;
  logic mon_busy = 1'b0;
  logic [15:0] exp_cnt[2];
  int last_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Event counters, sampled away from the active edge
  int s_rd_n = 0, f_rd_n = 0, s_err_n = 0, s_err_cyc = 0, s_low_n = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_if.fifo_rd_en === 1'b1) s_rd_n++;
      if (f_if.fifo_rd_en === 1'b1) f_rd_n++;
      if (s_if.rd_err === 1'b1) begin s_err_n++; s_err_cyc = cyc; end
      if (s_if.tx === 1'b0) s_low_n++;
    end
  end

  logic m_tx, m_busy, m_done;
  logic [15:0] m_cnt;
  assign m_tx   = mode ? f_if.tx          : s_if.tx;
  assign m_busy = mode ? f_if.busy        : s_if.busy;
  assign m_done = mode ? f_if.frame_done  : s_if.frame_done;
  assign m_cnt  = mode ? f_if.frame_count : s_if.frame_count;

  // Monitor: decode each frame off tx and compare against the expected queue
  initial begin : monitor
    logic [10:0] bits, e;
    int t_fall, fexp, nb;
    bit abort, bad_hold, bad_busy, early;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin exp_cnt[0] = '0; exp_cnt[1] = '0; continue; end
      if (m_tx !== 1'b0) continue;
      mon_busy = 1'b1;
      t_fall = cyc;
      nb = mode ? 11 : 10;
      bits = '0; abort = 0; bad_hold = 0; bad_busy = 0; early = 0;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 4; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (rst) begin abort = 1; break; end
          if (k == 0) bits[b] = m_tx;
          else if (m_tx !== bits[b]) bad_hold = 1;
          if (m_busy !== 1'b1) bad_busy = 1;
          if (m_done !== 1'b0) early = 1;
        end
        if (abort) break;
      end
      if (abort) begin
        exp_cnt[0] = '0; exp_cnt[1] = '0; mon_busy = 1'b0;
        continue;
      end
      @(negedge clk);
      check("done_pulse", {30'd0, m_done, early}, 32'd2);
      check("busy_span", {30'd0, bad_busy, m_busy}, 32'd0);
      check("bit_hold", {31'd0, bad_hold}, 32'd0);
      check("exp_avail", {31'd0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        fexp = fall_q.pop_front();
        check("frame_bits", {21'd0, bits}, {21'd0, e});
        if (fexp >= 0) check("start_edge", t_fall, fexp);
        // frame_done edge to next start edge: 3 standard (two extra idle cycles), 1 FWFT
        else if (fexp == -2) check("idle_gap", t_fall - last_done, mode ? 1 : 3);
      end
      exp_cnt[mode] = exp_cnt[mode] + 16'd1;
      check("frame_count", {16'd0, m_cnt}, {16'd0, exp_cnt[mode]});
      last_done = cyc;
      mon_busy = 1'b0;
    end
  end

  task automatic push(input logic to_fw, input logic [7:0] d, output int p);
    @(negedge clk);
    wr_data = d;
    if (to_fw) f_wr = 1'b1; else s_wr = 1'b1;
    p = cyc + 1;
    @(negedge clk);
    s_wr = 1'b0;
    f_wr = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'd0, (exp_q.size() == 0 && !mon_busy)}, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_tx", {31'd0, s_if.tx}, 32'd1);
    check("rst_busy", {31'd0, s_if.busy}, 32'd0);
    check("rst_rd_en", {31'd0, s_if.fifo_rd_en}, 32'd0);
    check("rst_count", {16'd0, s_if.frame_count}, 32'd0);
    check("rst_fw_tx", {31'd0, f_if.tx}, 32'd1);
  endtask

  initial begin : main
    int p, r0, e0, l0;
    #3 rst = 1'b1;
    #1;
    check_reset_values();
    check("rst_done", {31'd0, s_if.frame_done}, 32'd0);
    check("rst_err", {31'd0, s_if.rd_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single standard frame: 0xA5 -> {stop, data, start}
    r0 = s_rd_n;
    exp_q.push_back(11'h34A);
    push(1'b0, 8'hA5, p); fall_q.push_back(p + 3);
    drain(100);
    check("rd_pulses_single", s_rd_n - r0, 1);

    // burst of three
    r0 = s_rd_n;
    exp_q.push_back(11'h200); push(1'b0, 8'h00, p); fall_q.push_back(p + 3);
    exp_q.push_back(11'h3FE); push(1'b0, 8'hFF, p); fall_q.push_back(-2);
    exp_q.push_back(11'h278); push(1'b0, 8'h3C, p); fall_q.push_back(-2);
    drain(300);
    repeat (10) @(negedge clk);
    check("rd_pulses_burst", s_rd_n - r0, 3);

    // read timeout: the popped word never shows valid
    r0 = s_rd_n; e0 = s_err_n; l0 = s_low_n;
    suppress = 1'b1;
    push(1'b0, 8'h55, p);
    repeat (12) @(negedge clk);
    check("rd_err_count", s_err_n - e0, 1);
    check("rd_err_edge", s_err_cyc, p + 5);
    check("rd_pulses_timeout", s_rd_n - r0, 1);
    check("tx_idle_timeout", s_low_n - l0, 0);
    suppress = 1'b0;
    exp_q.push_back(11'h32C); push(1'b0, 8'h96, p); fall_q.push_back(p + 3);
    drain(100);

    // reset in the middle of DATA, new word queued while in reset
    push(1'b0, 8'h5A, p);
    while (cyc < p + 14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values();
    exp_q.push_back(11'h386);
    push(1'b0, 8'hC3, p);
    @(negedge clk);
    rst = 1'b0;
    fall_q.push_back(cyc + 3);
    drain(100);

    // FWFT with even parity
    mode = 1'b1;
    r0 = f_rd_n;
    exp_q.push_back(11'h60E); push(1'b1, 8'h07, p); fall_q.push_back(p + 1);
    drain(100);
    check("fw_rd_pulses_single", f_rd_n - r0, 1);
    exp_q.push_back(11'h502); push(1'b1, 8'h81, p); fall_q.push_back(p + 1);
    exp_q.push_back(11'h60E); push(1'b1, 8'h07, p); fall_q.push_back(-2);
    drain(200);
    repeat (5) @(negedge clk);
    check("fw_rd_pulses_total", f_rd_n - r0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains words from the `sync_fifo` and sends each as an asynchronous frame: start bit, WIDTH data bits LSB-first, optional even parity, and stop bit(s). It sits directly downstream of the FIFO. It consumes the FIFO's `data_out`, `empty` and `valid` outputs, and drives the FIFO's `rd_en` input. It supports the FIFO built both in standard mode and in first-word-fall-through (FWFT) mode.

## Interface
- `WIDTH`, 8: data word width; must match the FIFO width.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be at least 2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.
- `STOP_BITS`, 1: number of stop bits; must be 1 or 2.
- `FWFT`, 0: 1 means the FIFO presents its head word while `empty` is low.
- `clk`, input, 1: the single clock; all logic updates on its rising edge.
- `rst`, input, 1: reset; asynchronous and active-high.
- `fifo_data`, input, WIDTH: FIFO `data_out`.
- `fifo_empty`, input, 1: FIFO `empty`.
- `fifo_valid`, input, 1: FIFO `valid`; only used when FWFT=0.
- `fifo_rd_en`, output, 1: FIFO `rd_en`; one-cycle pop request.
- `tx`, output, 1: serial line; idles high.
- `busy`, output, 1: high from the word latch until the end of the stop bit(s).
- `frame_done`, output, 1: one-cycle pulse after the last stop bit.
- `rd_err`, output, 1: one-cycle pulse on a standard-mode read timeout.
- `frame_count`, output, 16: count of completed frames; wraps from 0xFFFF to 0.

## Operation
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, `rd_err`=0, `frame_count`=0. The state machine goes to IDLE and the bit-period and bit counters clear.
- States are IDLE, WAIT, START, DATA, PARITY and STOP.
- IDLE, standard mode (FWFT=0): on a sampled `fifo_empty`=0, assert `fifo_rd_en` for exactly one cycle and go to WAIT.
- IDLE, FWFT mode: on a sampled `fifo_empty`=0, latch `fifo_data`, assert `fifo_rd_en` for one cycle, drive `tx`=0, and go to START. WAIT is never entered.
- WAIT: on the first edge that samples `fifo_valid`=1, latch `fifo_data`, drive `tx`=0, set `busy`, and go to START.
  - If `fifo_valid` is not seen on any of the 4 edges after entering WAIT, pulse `rd_err` on the 4th edge and return to IDLE.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: the shift register drives bit 0 first. `tx` holds each bit for CLKS_PER_BIT cycles; after WIDTH bits, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: `tx` = XOR of all latched data bits, so the total count of 1s is even. Hold for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. On exit: `busy`=0, pulse `frame_done`, increment `frame_count` (16-bit wrap), go to IDLE.
- The bit-period counter runs 0..CLKS_PER_BIT-1 and its terminal count advances the bit. Every bit lasts exactly CLKS_PER_BIT cycles, with no jitter.
- `fifo_rd_en` is never asserted outside IDLE, so at most one pop is requested per frame. `fifo_empty` is ignored while not in IDLE.
- Reset mid-frame: `tx` goes to 1 immediately and the frame is truncated. A word already popped is discarded; no re-read is attempted.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Standard mode: IDLE samples non-empty at edge E0 → `fifo_rd_en` is high E0–E1 → FIFO `valid` is high after E1 → WAIT latches at E2 and `tx` falls at E2.
- FWFT mode: IDLE samples non-empty at E0 → `tx` falls at E0 → FIFO pops at E1.
- Frame length: (1 + WIDTH + PARITY_EN + STOP_BITS)×CLKS_PER_BIT cycles, measured from the `tx` fall to the `frame_done` edge.
- Back-to-back frames with a non-empty FIFO:
  - standard mode: 2 extra idle-high cycles after the stop bit(s);
  - FWFT mode: no extra idle cycles; the next start bit begins at the first IDLE edge.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `tx`=1, `busy`=0, `fifo_rd_en`=0 and `frame_count`=0 immediately, with no clock edge needed.
- Single frame, standard mode (WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0): FIFO holds 0xA5 → one `fifo_rd_en` pulse; `tx` = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; `frame_done` asserted once, 40 cycles after the `tx` fall; `frame_count`=1.
- Parity and FWFT (FWFT=1, PARITY_EN=1): FIFO holds 0x07 → `tx` falls on the same edge that samples `empty` low; parity bit = 1; frame is 44 cycles.
- Burst: FIFO holds 0x00, 0xFF, 0x3C in standard mode → exactly 3 `fifo_rd_en` pulses; data arrives in order; 2 idle cycles between frames; `frame_count`=3; no read is requested after `empty` rises.
- Read timeout: standard mode, `fifo_valid` held low after a `fifo_rd_en` pulse → `rd_err` pulses on the 4th WAIT edge; `tx` stays 1 throughout; returns to IDLE.
- Reset mid-DATA, then release with the FIFO non-empty → `tx`=1 at once; a new, complete frame starts under standard timing, and `frame_count` restarts at 0.
